// File: rtl/ocp_master_pkg.sv
// Shared OCP encodings and width constants for the bridge-side OCP master.
package ocp_master_pkg;

    localparam int MADDR_WIDTH = 64;
    localparam int MDATA_WIDTH = 8;
    localparam int SDATA_WIDTH = 8;

    typedef enum logic [2:0] {
        MCMD_IDLE = 3'b000,
        MCMD_WR   = 3'b001,
        MCMD_RD   = 3'b010,
        MCMD_RDEX = 3'b011,
        MCMD_RDL  = 3'b100,
        MCMD_WRNP = 3'b101,
        MCMD_WRC  = 3'b110,
        MCMD_BCST = 3'b111
    } mcmd_e;

    typedef enum logic [1:0] {
        SRESP_NULL = 2'b00,
        SRESP_DVA  = 2'b01,
        SRESP_FAIL = 2'b10,
        SRESP_ERR  = 2'b11
    } sresp_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_READ  = 2'b10
    } state_e;

endpackage

// File: rtl/ocp_master.sv
// OCP 2.2 master: turns bridge single/burst requests into OCP request beats
// with SCmdAccept handshaking and captures DVA read responses.
module ocp_master
    import ocp_master_pkg::*;
#(
    parameter int MADDR_W = MADDR_WIDTH,
    parameter int MDATA_W = MDATA_WIDTH,
    parameter int SDATA_W = SDATA_WIDTH
) (
    input  logic               sys_clk,
    input  logic               reset,
    input  logic               EnableClk,
    output logic               Clk,
    input  logic [MADDR_W-1:0] address,
    input  logic [9:0]         burst_length,
    input  logic [2:0]         burst_seq,
    input  logic               read_request,
    input  logic               write_request,
    input  logic [MDATA_W-1:0] write_data,
    output logic [MDATA_W-1:0] read_data,
    input  logic               SCmdAccept,
    input  logic [SDATA_W-1:0] SData,
    input  logic [1:0]         SResp,
    output logic [2:0]         MCmd,
    output logic [MADDR_W-1:0] MAddr,
    output logic [MDATA_W-1:0] MData,
    output logic [9:0]         MBurstLength,
    output logic               MReqLast
);

    state_e             state_q;
    mcmd_e              mcmd_q;
    logic [MADDR_W-1:0] maddr_q;
    logic [MDATA_W-1:0] mdata_q;
    logic [9:0]         mburst_q;
    logic               mreqlast_q;
    logic [MDATA_W-1:0] rdata_q;
    logic [9:0]         count_q;
    logic [2:0]         burst_seq_q;
    logic [9:0]         beats_d;
    logic               unused_burst_seq;

    // A zero-length request still moves one beat.
    assign beats_d = (burst_length == 10'd0) ? 10'd1 : burst_length;

    // Only INCR bursts are supported; the sequence code is kept for visibility only.
    assign unused_burst_seq = ^burst_seq_q;

    assign Clk = sys_clk & EnableClk;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mcmd_q      <= MCMD_IDLE;
            maddr_q     <= '0;
            mdata_q     <= '0;
            mburst_q    <= '0;
            mreqlast_q  <= 1'b0;
            rdata_q     <= '0;
            count_q     <= '0;
            burst_seq_q <= '0;
        end else if (EnableClk) begin
            if (SResp == SRESP_DVA) begin
                rdata_q <= SData;
            end
            case (state_q)
                ST_IDLE: begin
                    if (write_request || read_request) begin
                        state_q     <= write_request ? ST_WRITE : ST_READ;
                        mcmd_q      <= write_request ? MCMD_WR : MCMD_RD;
                        maddr_q     <= address;
                        mdata_q     <= write_request ? write_data : '0;
                        mburst_q    <= burst_length;
                        burst_seq_q <= burst_seq;
                        count_q     <= beats_d;
                        mreqlast_q  <= (beats_d == 10'd1);
                    end
                end
                default: begin
                    if (SCmdAccept) begin
                        count_q <= count_q - 10'd1;
                        if (count_q > 10'd1) begin
                            maddr_q    <= address;
                            mreqlast_q <= (count_q == 10'd2);
                            if (state_q == ST_WRITE) begin
                                mdata_q <= write_data;
                            end
                        end else begin
                            state_q    <= ST_IDLE;
                            mcmd_q     <= MCMD_IDLE;
                            mreqlast_q <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign MCmd         = mcmd_q;
    assign MAddr        = maddr_q;
    assign MData        = mdata_q;
    assign MBurstLength = mburst_q;
    assign MReqLast     = mreqlast_q;
    assign read_data    = rdata_q;

endmodule

// File: tb/tb_ocp_master.sv
// Self-checking bench for ocp_master: transaction-level reference model,
// per-cycle compare process and directed scenarios with literal checks.
module tb_ocp_master;

    logic        sys_clk = 1'b0;
    logic        reset = 1'b1;
    logic        EnableClk = 1'b1;
    logic        Clk;
    logic [63:0] address = '0;
    logic [9:0]  burst_length = '0;
    logic [2:0]  burst_seq = '0;
    logic        read_request = 1'b0;
    logic        write_request = 1'b0;
    logic [7:0]  write_data = '0;
    logic [7:0]  read_data;
    logic        SCmdAccept = 1'b0;
    logic [7:0]  SData = '0;
    logic [1:0]  SResp = '0;
    logic [2:0]  MCmd;
    logic [63:0] MAddr;
    logic [7:0]  MData;
    logic [9:0]  MBurstLength;
    logic        MReqLast;

    int testsRun = 0;
    int testsFailed = 0;

    ocp_master dut (
        .sys_clk(sys_clk), .reset(reset), .EnableClk(EnableClk), .Clk(Clk),
        .address(address), .burst_length(burst_length), .burst_seq(burst_seq),
        .read_request(read_request), .write_request(write_request),
        .write_data(write_data), .read_data(read_data), .SCmdAccept(SCmdAccept),
        .SData(SData), .SResp(SResp), .MCmd(MCmd), .MAddr(MAddr), .MData(MData),
        .MBurstLength(MBurstLength), .MReqLast(MReqLast)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: one outstanding transaction with a beat budget.
    bit          busy = 0;
    bit          isWrite = 0;
    bit          resetView = 1;
    int          beatsLeft = 0;
    logic [63:0] modelAddr = '0;
    logic [7:0]  modelData = '0;
    logic [9:0]  modelLen = '0;
    logic [7:0]  modelRead = '0;

    always @(posedge sys_clk) begin
        if (reset) begin
            busy = 0; beatsLeft = 0; resetView = 1;
            modelAddr = '0; modelData = '0; modelLen = '0; modelRead = '0;
        end else if (EnableClk) begin
            if (SResp == 2'b01) modelRead = SData;
            if (!busy) begin
                if (write_request || read_request) begin
                    busy = 1;
                    resetView = 0;
                    isWrite = write_request;
                    beatsLeft = (burst_length == 0) ? 1 : int'(burst_length);
                    modelAddr = address;
                    modelData = write_request ? write_data : 8'h00;
                    modelLen = burst_length;
                end
            end else if (SCmdAccept) begin
                beatsLeft--;
                if (beatsLeft == 0) begin
                    busy = 0;
                end else begin
                    modelAddr = address;
                    if (isWrite) modelData = write_data;
                end
            end
        end
    end

    // Every cycle: command, last flag, read data and Clk; request fields while meaningful.
    always @(posedge sys_clk) begin
        #1;
        checkOutput("MCmd", 64'(MCmd), busy ? (isWrite ? 64'd1 : 64'd2) : 64'd0);
        checkOutput("MReqLast", 64'(MReqLast), 64'(busy && beatsLeft == 1));
        checkOutput("read_data", 64'(read_data), 64'(modelRead));
        checkOutput("Clk", 64'(Clk), 64'(EnableClk));
        if (busy || resetView) begin
            checkOutput("MAddr", MAddr, modelAddr);
            checkOutput("MData", 64'(MData), 64'(modelData));
            checkOutput("MBurstLength", 64'(MBurstLength), 64'(modelLen));
        end
    end

    task automatic applyStimulus(input int cycles = 1);
        for (int i = 0; i < cycles; i++) begin
            @(posedge sys_clk);
            #2;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(2);
        checkOutput("reset MCmd", 64'(MCmd), 64'd0);
        checkOutput("reset MAddr", MAddr, 64'd0);
        checkOutput("reset read_data", 64'(read_data), 64'd0);
        reset = 1'b0;
        applyStimulus();

        // single write
        address = '1; write_data = 8'hFF; burst_length = 10'd1; write_request = 1'b1;
        applyStimulus();
        write_request = 1'b0;
        checkOutput("sw MCmd", 64'(MCmd), 64'd1);
        checkOutput("sw MAddr", MAddr, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("sw MData", 64'(MData), 64'hFF);
        checkOutput("sw MReqLast", 64'(MReqLast), 64'd1);
        applyStimulus(2);
        checkOutput("sw hold MCmd", 64'(MCmd), 64'd1);
        SCmdAccept = 1'b1;
        applyStimulus();
        SCmdAccept = 1'b0;
        checkOutput("sw idle MCmd", 64'(MCmd), 64'd0);

        // single read
        read_request = 1'b1; address = '1; burst_length = 10'd1;
        applyStimulus();
        read_request = 1'b0;
        checkOutput("sr MCmd", 64'(MCmd), 64'd2);
        checkOutput("sr MData", 64'(MData), 64'd0);
        SCmdAccept = 1'b1;
        applyStimulus();
        SCmdAccept = 1'b0;
        checkOutput("sr idle MCmd", 64'(MCmd), 64'd0);
        SResp = 2'b01; SData = 8'hFF;
        applyStimulus();
        SResp = 2'b00;
        checkOutput("sr read_data", 64'(read_data), 64'hFF);

        // burst write of 4
        address = 64'h0; write_data = 8'h00; burst_length = 10'd4; write_request = 1'b1;
        applyStimulus();
        write_request = 1'b0;
        checkOutput("bw MBurstLength", 64'(MBurstLength), 64'd4);
        checkOutput("bw first last", 64'(MReqLast), 64'd0);
        SCmdAccept = 1'b1;
        for (int b = 1; b < 4; b++) begin
            address = 64'(b * 4); write_data = 8'(b);
            applyStimulus();
            checkOutput("bw MAddr", MAddr, 64'(b * 4));
            checkOutput("bw MData", 64'(MData), 64'(b));
            checkOutput("bw MReqLast", 64'(MReqLast), 64'(b == 3));
        end
        applyStimulus();
        SCmdAccept = 1'b0;
        checkOutput("bw idle MCmd", 64'(MCmd), 64'd0);

        // burst read of 4, accept delayed 3 cycles
        address = 64'h0; burst_length = 10'd4; read_request = 1'b1;
        applyStimulus();
        read_request = 1'b0;
        for (int d = 0; d < 3; d++) begin
            applyStimulus();
            checkOutput("br wait MCmd", 64'(MCmd), 64'd2);
            checkOutput("br wait MAddr", MAddr, 64'h0);
        end
        SCmdAccept = 1'b1;
        for (int b = 1; b < 4; b++) begin
            address = 64'(b * 4);
            applyStimulus();
            checkOutput("br MAddr", MAddr, 64'(b * 4));
        end
        applyStimulus();
        SCmdAccept = 1'b0;
        checkOutput("br idle MCmd", 64'(MCmd), 64'd0);
        SResp = 2'b01;
        SData = 8'h04; applyStimulus(); checkOutput("br rd0", 64'(read_data), 64'h04);
        SData = 8'h08; applyStimulus(); checkOutput("br rd1", 64'(read_data), 64'h08);
        SData = 8'h0C; applyStimulus(); checkOutput("br rd2", 64'(read_data), 64'h0C);
        SData = 8'h20; applyStimulus(); checkOutput("br rd3", 64'(read_data), 64'h20);
        SData = 8'h55;
        SResp = 2'b10; applyStimulus(); checkOutput("FAIL resp keeps", 64'(read_data), 64'h20);
        SResp = 2'b11; applyStimulus(); checkOutput("ERR resp keeps", 64'(read_data), 64'h20);
        SResp = 2'b00; applyStimulus(); checkOutput("NULL resp keeps", 64'(read_data), 64'h20);

        // zero burst length behaves as a single beat
        address = 64'h40; write_data = 8'h5A; burst_length = 10'd0; write_request = 1'b1;
        applyStimulus();
        write_request = 1'b0;
        checkOutput("bl0 MReqLast", 64'(MReqLast), 64'd1);
        checkOutput("bl0 MBurstLength", 64'(MBurstLength), 64'd0);
        SCmdAccept = 1'b1; applyStimulus(); SCmdAccept = 1'b0;
        checkOutput("bl0 idle MCmd", 64'(MCmd), 64'd0);

        // EnableClk low freezes a burst in progress
        address = 64'h80; write_data = 8'h11; burst_length = 10'd2; write_request = 1'b1;
        applyStimulus();
        write_request = 1'b0; EnableClk = 1'b0; SCmdAccept = 1'b1;
        address = 64'h84; write_data = 8'h22;
        applyStimulus(2);
        checkOutput("gated MAddr", MAddr, 64'h80);
        EnableClk = 1'b1;
        applyStimulus(2);
        SCmdAccept = 1'b0;
        checkOutput("ungated idle MCmd", 64'(MCmd), 64'd0);

        // write wins over read, then reset mid-burst
        address = 64'h100; write_data = 8'hAA; burst_length = 10'd3;
        read_request = 1'b1; write_request = 1'b1;
        applyStimulus();
        read_request = 1'b0; write_request = 1'b0;
        checkOutput("prio MCmd", 64'(MCmd), 64'd1);
        checkOutput("prio MData", 64'(MData), 64'hAA);
        SCmdAccept = 1'b1; address = 64'h104;
        applyStimulus();
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0; SCmdAccept = 1'b0;
        checkOutput("rst MCmd", 64'(MCmd), 64'd0);
        checkOutput("rst MAddr", MAddr, 64'd0);
        checkOutput("rst MData", 64'(MData), 64'd0);
        checkOutput("rst MBurstLength", 64'(MBurstLength), 64'd0);
        checkOutput("rst MReqLast", 64'(MReqLast), 64'd0);
        checkOutput("rst read_data", 64'(read_data), 64'd0);

        // EnableClk low with a pending write request
        EnableClk = 1'b0; write_request = 1'b1; address = 64'h200; burst_length = 10'd1;
        for (int c = 0; c < 3; c++) begin
            applyStimulus();
            checkOutput("en0 MCmd", 64'(MCmd), 64'd0);
            checkOutput("en0 Clk", 64'(Clk), 64'd0);
        end
        write_request = 1'b0; EnableClk = 1'b1;
        applyStimulus(2);
        checkOutput("en1 MCmd", 64'(MCmd), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
